// File: rtl/axis_width_upsizer.sv
// axis_width_upsizer: packs a narrow AXI-Stream into wide little-endian words.
// Emits one word per RATIO input beats, or early on tlast, with lane keep.
module axis_width_upsizer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 512,
    localparam int RATIO    = OUT_WIDTH / IN_WIDTH,
    localparam int CW       = $clog2(RATIO)
) (
    input  logic                 s_axis_aclk,
    input  logic                 reset,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic [RATIO-1:0]     m_axis_tkeep,
    output logic                 m_axis_tlast
);

    logic [OUT_WIDTH-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_valid;
    logic [OUT_WIDTH-1:0] r_data;
    logic [RATIO-1:0]     r_keep;
    logic                 r_last;

    logic                 w_hs_in;
    logic                 w_hs_out;
    logic                 w_complete;
    logic [OUT_WIDTH-1:0] w_word;
    logic [RATIO-1:0]     w_keep;

    // Input is accepted whenever the output slot is free or draining now.
    assign s_axis_tready = ~reset & (~r_valid | m_axis_tready);
    assign w_hs_in       = s_axis_tvalid & s_axis_tready;
    assign w_hs_out      = r_valid & m_axis_tready;
    assign w_complete    = (r_cnt == CW'(RATIO - 1)) | s_axis_tlast;

    // Accumulator with the current lane overwritten, and keep mask 0..cnt.
    always_comb begin
        w_word = r_acc;
        w_word[r_cnt*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
        w_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            w_keep[k] = (CW'(k) <= r_cnt);
        end
    end

    // Lane accumulation; cleared whenever a word is handed to the output.
    always_ff @(posedge s_axis_aclk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_hs_in) begin
            if (w_complete) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_word;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register: loads on completion, drops valid only on handshake.
    always_ff @(posedge s_axis_aclk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (w_hs_in && w_complete) begin
            r_valid <= 1'b1;
            r_data  <= w_word;
            r_keep  <= w_keep;
            r_last  <= s_axis_tlast;
        end else if (w_hs_out) begin
            r_valid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_data;
    assign m_axis_tkeep  = r_keep;
    assign m_axis_tlast  = r_last;

endmodule
